param_vending_machine: RTL and testbench

PARAM_VENDING_MACHINE -- requirements
Module: param_vending_machine

---
 rtl/param_vending_machine.sv | 93 +++++++++
 tb/tb_param_vending_machine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/param_vending_machine.sv
// param_vending_machine: Moore vending FSM with parameterised item prices, coin collection and nickel change refund
module param_vending_machine #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 6,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {CREDIT_W'(6), CREDIT_W'(5), CREDIT_W'(4), CREDIT_W'(3)}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_ITEMS-1:0] item_sel,
    input  logic                 item_valid,
    input  logic                 nickel_in,
    input  logic                 dime_in,
    input  logic                 quarter_in,
    input  logic                 cancel,
    output logic                 dispense,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic                 nickel_out,
    output logic                 coin_reject,
    output logic                 busy,
    output logic [CREDIT_W-1:0]  credit
);
    localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DISPENSE = 2'd2, CHANGE = 2'd3;
    logic [1:0] state, state_d;
    logic [NUM_ITEMS-1:0] sel, sel_d;
    logic [CREDIT_W-1:0] credit_d, req_price, sel_price, remainder;
    logic [CREDIT_W+2:0] sum;
    logic [2:0] coin_val;
    logic any_coin, multi, overflow, reject_d;
    always_comb begin
        req_price = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            req_price = req_price | (item_sel[i] ? PRICES[i*CREDIT_W +: CREDIT_W] : '0);
            sel_price = sel_price | (sel[i] ? PRICES[i*CREDIT_W +: CREDIT_W] : '0);
        end
    end
    assign coin_val = quarter_in ? 3'd5 : dime_in ? 3'd2 : {2'b0, nickel_in};
    assign any_coin = quarter_in | dime_in | nickel_in;
    assign multi = (quarter_in & (dime_in | nickel_in)) | (dime_in & nickel_in);
    assign sum = {3'b0, credit} + {{CREDIT_W{1'b0}}, coin_val};
    // credit saturates by refusing the coin, never by wrapping
    assign overflow = |sum[CREDIT_W+2:CREDIT_W];
    assign remainder = credit - sel_price;
    always_comb begin
        state_d = state;
        credit_d = credit;
        sel_d = sel;
        reject_d = any_coin;
        case (state)
            IDLE: begin
                credit_d = '0;
                if (item_valid && $onehot(item_sel) && req_price != '0) begin
                    sel_d = item_sel;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d = credit != '0 ? CHANGE : IDLE;
                end else begin
                    reject_d = multi | (any_coin & overflow);
                    credit_d = overflow ? credit : sum[CREDIT_W-1:0];
                    state_d = (!overflow && sum[CREDIT_W-1:0] >= sel_price) ? DISPENSE : COLLECT;
                end
            end
            DISPENSE: begin
                credit_d = remainder;
                state_d = remainder != '0 ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_d = credit - CREDIT_W'(1);
                state_d = credit == CREDIT_W'(1) ? IDLE : CHANGE;
            end
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            credit <= '0;
            sel <= '0;
            coin_reject <= 1'b0;
        end else begin
            state <= state_d;
            credit <= credit_d;
            sel <= sel_d;
            coin_reject <= reject_d;
        end
    end
    assign dispense = state == DISPENSE;
    assign item_out = dispense ? sel : '0;
    assign nickel_out = state == CHANGE;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_param_vending_machine.sv
// tb_param_vending_machine: scoreboard bench for two vending machine configurations (default and 3-bit credit)
module tb_param_vending_machine;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;
    logic [3:0] sel_i [2];
    logic iv [2], ni [2], di [2], qi [2], ca [2];
    logic disp [2], nout [2], crej [2], bsy [2];
    logic [3:0] iout [2];
    logic [5:0] cr0;
    logic [2:0] cr1;

    param_vending_machine dut0 (
        .clock(clock), .reset(reset), .item_sel(sel_i[0]), .item_valid(iv[0]),
        .nickel_in(ni[0]), .dime_in(di[0]), .quarter_in(qi[0]), .cancel(ca[0]),
        .dispense(disp[0]), .item_out(iout[0]), .nickel_out(nout[0]),
        .coin_reject(crej[0]), .busy(bsy[0]), .credit(cr0)
    );

    param_vending_machine #(.NUM_ITEMS(4), .CREDIT_W(3), .PRICES({3'd7, 3'd0, 3'd4, 3'd3})) dut1 (
        .clock(clock), .reset(reset), .item_sel(sel_i[1]), .item_valid(iv[1]),
        .nickel_in(ni[1]), .dime_in(di[1]), .quarter_in(qi[1]), .cancel(ca[1]),
        .dispense(disp[1]), .item_out(iout[1]), .nickel_out(nout[1]),
        .coin_reject(crej[1]), .busy(bsy[1]), .credit(cr1)
    );

    int total = 0, bad = 0;
    int price_tab [2][4] = '{'{3, 4, 5, 6}, '{3, 4, 0, 7}};
    int cmax [2] = '{63, 7};
    int disp_q [2][$];
    int chg_q [2][$];
    int rej_exp [2] = '{0, 0};
    int rej_cnt [2] = '{0, 0};
    int run [2] = '{0, 0};
    bit sb_on = 1'b1;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int credit_of(int k);
        return k == 0 ? int'(cr0) : int'(cr1);
    endfunction

    function automatic logic [3:0] rnd_cc();
        return {($urandom % 12) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0};
    endfunction

    // cc = {cancel, quarter, dime, nickel}; the idle DUT always gets zeros
    task automatic drive(int k, logic [3:0] s, logic v, logic [3:0] cc);
        for (int j = 0; j < 2; j++) begin
            sel_i[j] = j == k ? s : 4'b0;
            iv[j] = j == k ? v : 1'b0;
            ca[j] = j == k ? cc[3] : 1'b0;
            qi[j] = j == k ? cc[2] : 1'b0;
            di[j] = j == k ? cc[1] : 1'b0;
            ni[j] = j == k ? cc[0] : 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (sb_on && reset) begin
            for (int k = 0; k < 2; k++) begin
                if (disp[k]) begin
                    if (disp_q[k].size() == 0) chk($sformatf("dispense_expected%0d", k), disp_q[k].size(), 1);
                    else chk($sformatf("item_out%0d", k), int'(iout[k]), disp_q[k].pop_front());
                end else if (iout[k] != 4'b0) begin
                    chk($sformatf("item_out_quiet%0d", k), int'(iout[k]), 0);
                end
                if (nout[k]) run[k]++;
                else if (run[k] > 0) begin
                    if (chg_q[k].size() == 0) chk($sformatf("change_expected%0d", k), chg_q[k].size(), 1);
                    else chk($sformatf("refund%0d", k), run[k], chg_q[k].pop_front());
                    run[k] = 0;
                end
                if (crej[k]) rej_cnt[k]++;
            end
        end
    end

    // one customer interaction: selection cycle, coin collection, then the vend/refund tail
    task automatic txn(int k, logic [3:0] s, logic v, logic [3:0] scc, bit directed, logic [15:0] script, int len);
        int p, c, r, idx, i, val;
        bit ok, fin, dsp, rj;
        logic [3:0] cc;
        @(negedge clock);
        chk("idle_busy", int'(bsy[k]), 0);
        chk("idle_credit", credit_of(k), 0);
        drive(k, s, v, scc);
        if (|scc[2:0]) rej_exp[k]++;
        idx = 0;
        for (int j = 0; j < 4; j++) if (s[j]) idx = j;
        ok = v && $countones(s) == 1 && price_tab[k][idx] != 0;
        if (!ok) return;
        p = price_tab[k][idx];
        c = 0; r = 0; i = 0; fin = 0; dsp = 0;
        while (!fin) begin
            @(negedge clock);
            chk("collect_busy", int'(bsy[k]), 1);
            chk("collect_credit", credit_of(k), c);
            cc = directed ? (i < len ? script[i*4 +: 4] : 4'b1000) : (i >= 25 ? 4'b1000 : rnd_cc());
            i++;
            if (directed) drive(k, 4'b0, 1'b0, cc);
            else drive(k, 4'($urandom), 1'($urandom), cc);
            if (cc[3]) begin
                if (|cc[2:0]) rej_exp[k]++;
                r = c;
                fin = 1;
            end else begin
                val = cc[2] ? 5 : cc[1] ? 2 : cc[0] ? 1 : 0;
                rj = $countones(cc[2:0]) > 1;
                if (val > 0 && c + val > cmax[k]) rj = 1;
                else c += val;
                if (rj) rej_exp[k]++;
                if (c >= p) begin
                    dsp = 1;
                    r = c - p;
                    fin = 1;
                end
            end
        end
        if (dsp) disp_q[k].push_back(1 << idx);
        if (r > 0) chg_q[k].push_back(r);
        for (int j = 0; j < int'(dsp) + r; j++) begin
            @(negedge clock);
            if (j == 0) chk("final_credit", credit_of(k), c);
            cc = directed ? 4'b0 : rnd_cc();
            if (directed) drive(k, 4'b0, 1'b0, cc);
            else drive(k, 4'($urandom), 1'($urandom), cc);
            if (|cc[2:0]) rej_exp[k]++;
        end
    endtask

    initial begin
        int k;
        logic [3:0] s;
        logic v;
        reset = 1'b0;
        drive(0, 4'b0, 1'b0, 4'b0);
        repeat (2) @(negedge clock);
        for (int j = 0; j < 2; j++) begin
            chk("rst_dispense", int'(disp[j]), 0);
            chk("rst_item_out", int'(iout[j]), 0);
            chk("rst_nickel", int'(nout[j]), 0);
            chk("rst_reject", int'(crej[j]), 0);
            chk("rst_busy", int'(bsy[j]), 0);
        end
        chk("rst_credit0", int'(cr0), 0);
        chk("rst_credit1", int'(cr1), 0);
        reset = 1'b1;
        txn(0, 4'b0001, 1'b1, 4'b0, 1'b1, 16'h0021, 2);
        txn(0, 4'b0001, 1'b1, 4'b0, 1'b1, 16'h0022, 2);
        txn(0, 4'b1000, 1'b1, 4'b0, 1'b1, 16'h00A1, 2);
        txn(0, 4'b0010, 1'b1, 4'b0, 1'b1, 16'h0006, 1);
        txn(1, 4'b1000, 1'b1, 4'b0, 1'b1, 16'h0024, 2);
        txn(1, 4'b1000, 1'b1, 4'b0, 1'b1, 16'h0244, 3);
        txn(1, 4'b0000, 1'b0, 4'b0111, 1'b1, 16'h0, 0);
        txn(0, 4'b0011, 1'b1, 4'b0, 1'b1, 16'h0, 0);
        txn(0, 4'b0000, 1'b1, 4'b0, 1'b1, 16'h0, 0);
        txn(0, 4'b0001, 1'b0, 4'b0, 1'b1, 16'h0, 0);
        txn(1, 4'b0100, 1'b1, 4'b0, 1'b1, 16'h0, 0);
        repeat (150) begin
            k = int'($urandom % 2);
            if ($urandom % 4 != 0) begin
                s = 4'(1 << ($urandom % 4));
                v = 1'b1;
            end else begin
                s = 4'($urandom);
                v = 1'($urandom);
            end
            txn(k, s, v, ($urandom % 3 == 0) ? rnd_cc() : 4'b0, 1'b0, 16'h0, 0);
        end
        repeat (4) begin
            @(negedge clock);
            drive(0, 4'b0, 1'b0, 4'b0);
        end
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("reject_total%0d", j), rej_cnt[j], rej_exp[j]);
            chk($sformatf("dispense_left%0d", j), disp_q[j].size(), 0);
            chk($sformatf("change_left%0d", j), chg_q[j].size(), 0);
        end
        sb_on = 1'b0;
        @(negedge clock); drive(0, 4'b1000, 1'b1, 4'b0);
        @(negedge clock); drive(0, 4'b0, 1'b0, 4'b0001);
        @(negedge clock); drive(0, 4'b0, 1'b0, 4'b0010);
        @(negedge clock); drive(0, 4'b0, 1'b0, 4'b1000);
        @(negedge clock); drive(0, 4'b0, 1'b0, 4'b0);
        chk("change_credit", int'(cr0), 3);
        chk("change_nickel", int'(nout[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_credit", int'(cr0), 0);
        chk("async_busy", int'(bsy[0]), 0);
        chk("async_nickel", int'(nout[0]), 0);
        chk("async_dispense", int'(disp[0]), 0);
        chk("async_item_out", int'(iout[0]), 0);
        chk("async_reject", int'(crej[0]), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("post_rst_busy", int'(bsy[0]), 0);
            chk("post_rst_credit", int'(cr0), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
